// File: rtl/module_display_mux.sv
// Time-multiplexed scanner for a multi-digit 7-segment display: walks the digits,
// presents each nibble to the decoder and swaps in new values only at frame boundaries.
module module_display_mux #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 27000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic                  blank_lz_i,
    output logic [3:0]            data_o,
    output logic [N_DIGITS-1:0]   anodos_o,
    output logic                  blank_o,
    output logic                  pend_o
);

    localparam int PRE_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d;
    logic [4*N_DIGITS-1:0]   pendVal_q, pendVal_d;
    logic                    pend_q, pend_d;

    logic                    tick;
    logic                    boundary;
    logic [N_DIGITS-1:0]     upperZero;
    logic                    zeroRun;
    logic                    supp_d;
    logic [3:0]              nibble_d;
    logic [N_DIGITS-1:0]     anode_d;

    assign tick     = (pre_q == PRE_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        disp_d    = disp_q;
        pendVal_d = pendVal_q;
        pend_d    = pend_q;
        // A load landing on the boundary edge bypasses the pending register.
        if (boundary) begin
            if (load_i) begin
                disp_d = data_i;
            end else if (pend_q) begin
                disp_d = pendVal_q;
            end
            pend_d = 1'b0;
        end else if (load_i) begin
            pendVal_d = data_i;
            pend_d    = 1'b1;
        end
    end

    // Outputs are built from the next state so the anode and nibble switch together.
    always_comb begin
        upperZero = '0;
        zeroRun   = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zeroRun      = zeroRun & (disp_d[4*k +: 4] == 4'h0);
            upperZero[k] = zeroRun;
        end

        nibble_d = 4'h0;
        supp_d   = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nibble_d = disp_d[4*k +: 4];
                supp_d   = blank_lz_i && (k != 0) && upperZero[k];
            end
        end

        anode_d = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((idx_d == IDX_W'(k)) && !supp_d) begin
                anode_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            pendVal_q <= '0;
            pend_q    <= 1'b0;
            data_o    <= 4'h0;
            anodos_o  <= '1;
            blank_o   <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pendVal_q <= pendVal_d;
            pend_q    <= pend_d;
            data_o    <= supp_d ? 4'h0 : nibble_d;
            anodos_o  <= anode_d;
            blank_o   <= supp_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: tb/tb_module_display_mux.sv
// Directed bench for module_display_mux with 4 digits and a 4-cycle dwell.
module tb_module_display_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        loadI;
    logic [15:0] dataI;
    logic        blankLzI;
    logic [3:0]  dataO;
    logic [3:0]  anodosO;
    logic        blankO;
    logic        pendO;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    module_display_mux #(
        .N_DIGITS      (4),
        .REFRESH_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_i    (loadI),
        .data_i    (dataI),
        .blank_lz_i(blankLzI),
        .data_o    (dataO),
        .anodos_o  (anodosO),
        .blank_o   (blankO),
        .pend_o    (pendO)
    );

    always #5 clk = ~clk;

    // cyc counts active edges since reset release; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; loadI = 1'b0; dataI = 16'h0; blankLzI = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 4;
            if (anodosO !== 4'b1111) begin errors++; $display("[TB] FAIL reset_anodos got=%b want=1111", anodosO); end
            if (blankO !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank got=%b want=1", blankO); end
            if (dataO !== 4'h0) begin errors++; $display("[TB] FAIL reset_data got=%h want=0", dataO); end
            if (pendO !== 1'b0) begin errors++; $display("[TB] FAIL reset_pend got=%b want=0", pendO); end
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_scan();
        logic [1:0] dig;
        logic [3:0] expAn;
        while (cyc < 20) begin
            step();
            dig   = 2'((cyc / 4) % 4);
            expAn = ~(4'b0001 << dig);
            checks += 4;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL scan_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== 4'h0) begin errors++; $display("[TB] FAIL scan_data cyc=%0d got=%h want=0", cyc, dataO); end
            if (blankO !== 1'b0) begin errors++; $display("[TB] FAIL scan_blank cyc=%0d got=%b want=0", cyc, blankO); end
            if (pendO !== 1'b0) begin errors++; $display("[TB] FAIL scan_pend cyc=%0d got=%b want=0", cyc, pendO); end
        end
    endtask

    task automatic test_display_value();
        logic [1:0]  dig;
        logic [3:0]  expAn, expDat;
        logic [15:0] expVal;
        logic        expPend;
        while (cyc < 47) begin
            loadI = (cyc == 20);
            dataI = 16'hA3C5;
            step();
            loadI   = 1'b0;
            expVal  = (cyc >= 32) ? 16'hA3C5 : 16'h0000;
            expPend = (cyc < 32);
            dig     = 2'((cyc / 4) % 4);
            expAn   = ~(4'b0001 << dig);
            expDat  = expVal[{dig, 2'b00} +: 4];
            checks += 4;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL value_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== expDat) begin errors++; $display("[TB] FAIL value_data cyc=%0d got=%h want=%h", cyc, dataO, expDat); end
            if (blankO !== 1'b0) begin errors++; $display("[TB] FAIL value_blank cyc=%0d got=%b want=0", cyc, blankO); end
            if (pendO !== expPend) begin errors++; $display("[TB] FAIL value_pend cyc=%0d got=%b want=%b", cyc, pendO, expPend); end
        end
    endtask

    task automatic test_frame_atomicity();
        logic [1:0]  dig;
        logic [3:0]  expAn, expDat;
        logic [15:0] expVal;
        logic        expPend;
        while (cyc < 79) begin
            loadI = (cyc == 48) || (cyc == 56);
            dataI = (cyc == 48) ? 16'h1234 : 16'h5678;
            step();
            loadI   = 1'b0;
            expVal  = (cyc >= 64) ? 16'h5678 : 16'hA3C5;
            expPend = (cyc >= 49) && (cyc < 64);
            dig     = 2'((cyc / 4) % 4);
            expAn   = ~(4'b0001 << dig);
            expDat  = expVal[{dig, 2'b00} +: 4];
            checks += 3;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL atomic_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== expDat) begin errors++; $display("[TB] FAIL atomic_data cyc=%0d got=%h want=%h", cyc, dataO, expDat); end
            if (pendO !== expPend) begin errors++; $display("[TB] FAIL atomic_pend cyc=%0d got=%b want=%b", cyc, pendO, expPend); end
        end
    endtask

    task automatic test_boundary_bypass();
        logic [1:0]  dig;
        logic [3:0]  expAn, expDat;
        logic [15:0] expVal;
        while (cyc < 95) begin
            loadI = (cyc == 79);
            dataI = 16'hBEEF;
            step();
            loadI  = 1'b0;
            expVal = 16'hBEEF;
            dig    = 2'((cyc / 4) % 4);
            expAn  = ~(4'b0001 << dig);
            expDat = expVal[{dig, 2'b00} +: 4];
            checks += 3;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL bypass_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== expDat) begin errors++; $display("[TB] FAIL bypass_data cyc=%0d got=%h want=%h", cyc, dataO, expDat); end
            if (pendO !== 1'b0) begin errors++; $display("[TB] FAIL bypass_pend cyc=%0d got=%b want=0", cyc, pendO); end
        end
    endtask

    task automatic test_leading_zero();
        logic [1:0]  dig;
        logic [3:0]  expAn, expDat;
        logic [15:0] expVal;
        logic        expPend, lzOn, sup;
        while (cyc < 143) begin
            loadI = (cyc == 96) || (cyc == 112);
            dataI = (cyc == 96) ? 16'h0070 : 16'h0000;
            if (cyc == 96) blankLzI = 1'b1;
            if (cyc == 135) blankLzI = 1'b0;
            step();
            loadI   = 1'b0;
            expVal  = (cyc < 112) ? 16'hBEEF : ((cyc < 128) ? 16'h0070 : 16'h0000);
            expPend = ((cyc >= 97) && (cyc < 112)) || ((cyc >= 113) && (cyc < 128));
            lzOn    = (cyc >= 97) && (cyc < 136);
            dig     = 2'((cyc / 4) % 4);
            sup     = lzOn && (dig != 2'd0) && ((expVal >> {dig, 2'b00}) == 16'h0);
            expAn   = sup ? 4'b1111 : ~(4'b0001 << dig);
            expDat  = sup ? 4'h0 : expVal[{dig, 2'b00} +: 4];
            checks += 4;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL lz_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== expDat) begin errors++; $display("[TB] FAIL lz_data cyc=%0d got=%h want=%h", cyc, dataO, expDat); end
            if (blankO !== sup) begin errors++; $display("[TB] FAIL lz_blank cyc=%0d got=%b want=%b", cyc, blankO, sup); end
            if (pendO !== expPend) begin errors++; $display("[TB] FAIL lz_pend cyc=%0d got=%b want=%b", cyc, pendO, expPend); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] dig;
        logic [3:0] expAn;
        logic       expPend;
        while (cyc < 150) begin
            loadI = (cyc == 144);
            dataI = 16'h9999;
            step();
            loadI   = 1'b0;
            expPend = (cyc >= 145);
            checks += 2;
            if (dataO !== 4'h0) begin errors++; $display("[TB] FAIL midpre_data cyc=%0d got=%h want=0", cyc, dataO); end
            if (pendO !== expPend) begin errors++; $display("[TB] FAIL midpre_pend cyc=%0d got=%b want=%b", cyc, pendO, expPend); end
        end
        rst = 1'b1;
        #1;
        checks += 3;
        if (anodosO !== 4'b1111) begin errors++; $display("[TB] FAIL midrst_anodos got=%b want=1111", anodosO); end
        if (blankO !== 1'b1) begin errors++; $display("[TB] FAIL midrst_blank got=%b want=1", blankO); end
        if (pendO !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pend got=%b want=0", pendO); end
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            step();
            dig   = 2'((cyc / 4) % 4);
            expAn = ~(4'b0001 << dig);
            checks += 3;
            if (anodosO !== expAn) begin errors++; $display("[TB] FAIL midpost_anodos cyc=%0d got=%b want=%b", cyc, anodosO, expAn); end
            if (dataO !== 4'h0) begin errors++; $display("[TB] FAIL midpost_data cyc=%0d got=%h want=0", cyc, dataO); end
            if (pendO !== 1'b0) begin errors++; $display("[TB] FAIL midpost_pend cyc=%0d got=%b want=0", cyc, pendO); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_display_value();
        test_frame_atomicity();
        test_boundary_bypass();
        test_leading_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
